// File: rtl/dmem_bus_if.sv
// dmem_bus_if: registered request/acknowledge data-bus master behind the memory-access stage.
// Optional ack timeout with error pulse when DBUS_TIMEOUT_EN is defined.
module dmem_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_req_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] rbuf;
    logic        tmo;
    logic        unused_addr;

    assign unused_addr = ^mem_addr_i[1:0];

`ifdef DBUS_TIMEOUT_EN
    logic [7:0] cnt;

    // Counter only matters in BUSY/DRAIN; clearing on every state change covers both entries.
    assign tmo = (cnt + 8'd1) == 8'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            cnt       <= (state_nxt != state) ? '0 : bus_ack_i ? cnt : cnt + 8'd1;
            bus_err_o <= state == BUSY && state_nxt == DONE && !bus_ack_i;
        end
`else
    logic unused_tmo;

    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
    assign bus_err_o  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = (mem_ce_i && !flush_i) ? BUSY : IDLE;
            BUSY:  state_nxt = bus_ack_i ? (flush_i ? IDLE : DONE) : flush_i ? DRAIN : tmo ? DONE : BUSY;
            DONE:  state_nxt = (flush_i || !stall_i) ? IDLE : DONE;
            DRAIN: state_nxt = (bus_ack_i || tmo) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
            rbuf        <= '0;
        end else begin
            state     <= state_nxt;
            bus_req_o <= state_nxt == BUSY || state_nxt == DRAIN;
            if (state == IDLE && state_nxt == BUSY) begin
                bus_we_o    <= mem_we_i;
                bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                bus_sel_o   <= mem_sel_i;
                bus_wdata_o <= mem_wdata_i;
            end
            // Stores and timed-out requests both leave zero in the read buffer.
            if (state == BUSY && state_nxt == DONE)
                rbuf <= (bus_ack_i && !bus_we_o) ? bus_rdata_i : '0;
        end

    assign mem_rdata_o = (state == DONE) ? rbuf : '0;
    assign stall_req_o = (state == IDLE && mem_ce_i && !flush_i) || state == BUSY || state == DRAIN;
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed and randomized checks of dmem_bus_if against a transaction-level model.
module tb_dmem_bus_if;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i, stall_i, flush_i, bus_ack_i;
    logic [31:0] mem_addr_i, mem_wdata_i, bus_rdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o, bus_addr_o, bus_wdata_o;
    logic        stall_req_o, bus_req_o, bus_we_o, bus_err_o;
    logic [3:0]  bus_sel_o;
    int checks = 0;
    int passed = 0;

    dmem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i), .stall_i(stall_i), .flush_i(flush_i),
        .mem_rdata_o(mem_rdata_o), .stall_req_o(stall_req_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_sel_i = 0; mem_wdata_i = 0;
        stall_i = 0; flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1; #1 rst = 0;
        @(negedge clk);
        checks++; if ({bus_req_o, stall_req_o, mem_rdata_o} !== 34'h0) $display("FAIL reset_init got %h want 0", {bus_req_o, stall_req_o, mem_rdata_o}); else passed++;
        tick(); rst = 1;
        mem_ce_i = 1; mem_addr_i = 32'h40; mem_sel_i = 4'hf;
        tick();
        @(negedge clk);
        checks++; if (bus_req_o !== 1'b1) $display("FAIL reset_busy_req got %b want 1", bus_req_o); else passed++;
        #1 rst = 0; mem_ce_i = 0;
        #1;
        checks++; if ({bus_req_o, mem_rdata_o, bus_err_o} !== 34'h0) $display("FAIL reset_mid_busy got %h want 0", {bus_req_o, mem_rdata_o, bus_err_o}); else passed++;
        tick(); rst = 1;
        @(negedge clk);
        checks++; if ({stall_req_o, bus_req_o} !== 2'b00) $display("FAIL reset_release got %b want 00", {stall_req_o, bus_req_o}); else passed++;
        tick();
    endtask

    task automatic test_load();
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h106; mem_sel_i = 4'hf;
        @(negedge clk);
        checks++; if ({stall_req_o, bus_req_o} !== 2'b10) $display("FAIL load_c0 got %b want 10", {stall_req_o, bus_req_o}); else passed++;
        tick();
        bus_ack_i = 1; bus_rdata_i = 32'h11223344;
        @(negedge clk);
        checks++; if ({stall_req_o, bus_req_o, bus_we_o, bus_addr_o} !== {3'b110, 32'h104}) $display("FAIL load_c1 got %h want %h", {stall_req_o, bus_req_o, bus_we_o, bus_addr_o}, {3'b110, 32'h104}); else passed++;
        tick();
        bus_ack_i = 0; bus_rdata_i = $urandom;
        @(negedge clk);
        checks++; if ({mem_rdata_o, stall_req_o, bus_req_o, bus_err_o} !== {32'h11223344, 3'b000}) $display("FAIL load_c2 got %h want %h", {mem_rdata_o, stall_req_o, bus_req_o, bus_err_o}, {32'h11223344, 3'b000}); else passed++;
        tick();
        mem_ce_i = 0;
        @(negedge clk);
        checks++; if ({mem_rdata_o, stall_req_o} !== 33'h0) $display("FAIL load_c3 got %h want 0", {mem_rdata_o, stall_req_o}); else passed++;
        tick();
    endtask

    task automatic test_store();
        mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h2003; mem_sel_i = 4'b0011; mem_wdata_i = 32'hBEEFBEEF;
        @(negedge clk);
        checks++; if (stall_req_o !== 1'b1) $display("FAIL store_c0 got %b want 1", stall_req_o); else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_ack_i = (i == 3); bus_rdata_i = $urandom;
            mem_wdata_i = $urandom; mem_sel_i = 4'($urandom); mem_addr_i = $urandom;
            @(negedge clk);
            checks++;
            if ({stall_req_o, bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {3'b111, 32'h2000, 4'b0011, 32'hBEEFBEEF})
                $display("FAIL store_busy%0d got %h want %h", i, {stall_req_o, bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o}, {3'b111, 32'h2000, 4'b0011, 32'hBEEFBEEF});
            else passed++;
            tick();
        end
        bus_ack_i = 0;
        @(negedge clk);
        checks++; if ({mem_rdata_o, stall_req_o, bus_req_o} !== 34'h0) $display("FAIL store_done got %h want 0", {mem_rdata_o, stall_req_o, bus_req_o}); else passed++;
        tick();
        quiet();
        tick();
    endtask

    task automatic test_done_stall();
        logic [31:0] rd = $urandom;
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h3008; mem_sel_i = 4'hf;
        tick();
        tick();
        bus_ack_i = 1; bus_rdata_i = rd;
        tick();
        bus_ack_i = 0; bus_rdata_i = ~rd;
        for (int h = 0; h < 3; h++) begin
            stall_i = (h < 2);
            @(negedge clk);
            checks++; if ({mem_rdata_o, stall_req_o, bus_req_o} !== {rd, 2'b00}) $display("FAIL done_hold%0d got %h want %h", h, {mem_rdata_o, stall_req_o, bus_req_o}, {rd, 2'b00}); else passed++;
            tick();
        end
        stall_i = 0; mem_ce_i = 0;
        @(negedge clk);
        checks++; if ({mem_rdata_o, stall_req_o, bus_req_o} !== 34'h0) $display("FAIL done_release got %h want 0", {mem_rdata_o, stall_req_o, bus_req_o}); else passed++;
        tick();
    endtask

    task automatic test_flush();
        mem_ce_i = 1; flush_i = 1; mem_addr_i = 32'h500; mem_sel_i = 4'hf;
        @(negedge clk);
        checks++; if (stall_req_o !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", stall_req_o); else passed++;
        tick();
        flush_i = 0;
        @(negedge clk);
        checks++; if ({bus_req_o, stall_req_o} !== 2'b01) $display("FAIL flush_idle_req got %b want 01", {bus_req_o, stall_req_o}); else passed++;
        tick();
        flush_i = 1;
        @(negedge clk);
        checks++; if (bus_req_o !== 1'b1) $display("FAIL flush_busy got %b want 1", bus_req_o); else passed++;
        tick();
        flush_i = 0; mem_ce_i = 0;
        for (int i = 0; i < 2; i++) begin
            bus_ack_i = (i == 1); bus_rdata_i = $urandom;
            @(negedge clk);
            checks++; if ({bus_req_o, stall_req_o, mem_rdata_o} !== {2'b11, 32'h0}) $display("FAIL flush_drain%0d got %h want %h", i, {bus_req_o, stall_req_o, mem_rdata_o}, {2'b11, 32'h0}); else passed++;
            tick();
        end
        bus_ack_i = 0;
        @(negedge clk);
        checks++; if ({bus_req_o, stall_req_o, mem_rdata_o} !== 34'h0) $display("FAIL flush_end got %h want 0", {bus_req_o, stall_req_o, mem_rdata_o}); else passed++;
        tick();
    endtask

    task automatic test_random();
        logic        we, fl;
        logic [31:0] a, wd, rd, exp;
        logic [3:0]  sel;
        int          waits, hold;
        for (int t = 0; t < 24; t++) begin
            we = 1'($urandom); a = $urandom; wd = $urandom; rd = $urandom; sel = 4'($urandom);
            waits = $urandom_range(0, 3); hold = $urandom_range(0, 2); fl = ($urandom_range(0, 3) == 0);
            exp = we ? 32'h0 : rd;
            mem_ce_i = 1; mem_we_i = we; mem_addr_i = a; mem_sel_i = sel; mem_wdata_i = wd;
            @(negedge clk);
            checks++; if (stall_req_o !== 1'b1) $display("FAIL rnd%0d_start got %b want 1", t, stall_req_o); else passed++;
            tick();
            for (int i = 0; i <= waits; i++) begin
                bus_ack_i = (i == waits); flush_i = fl && (i == waits); bus_rdata_i = (i == waits) ? rd : $urandom;
                @(negedge clk);
                checks++;
                if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {1'b1, we, a & 32'hFFFF_FFFC, sel, wd})
                    $display("FAIL rnd%0d_bus got %h want %h", t, {bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o}, {1'b1, we, a & 32'hFFFF_FFFC, sel, wd});
                else passed++;
                tick();
            end
            bus_ack_i = 0; flush_i = 0;
            if (!fl)
                for (int h = 0; h <= hold; h++) begin
                    stall_i = (h < hold);
                    @(negedge clk);
                    checks++; if ({mem_rdata_o, stall_req_o, bus_req_o, bus_err_o} !== {exp, 3'b000}) $display("FAIL rnd%0d_done got %h want %h", t, {mem_rdata_o, stall_req_o, bus_req_o, bus_err_o}, {exp, 3'b000}); else passed++;
                    tick();
                end
            stall_i = 0; mem_ce_i = 0;
            @(negedge clk);
            checks++; if ({mem_rdata_o, stall_req_o, bus_req_o} !== 34'h0) $display("FAIL rnd%0d_idle got %h want 0", t, {mem_rdata_o, stall_req_o, bus_req_o}); else passed++;
            tick();
        end
    endtask

`ifdef DBUS_TIMEOUT_EN
    task automatic test_timeout();
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h600; mem_sel_i = 4'hf;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({bus_req_o, stall_req_o} !== 2'b11) $display("FAIL tmo_busy%0d got %b want 11", i, {bus_req_o, stall_req_o}); else passed++;
            tick();
        end
        stall_i = 1;
        @(negedge clk);
        checks++; if ({mem_rdata_o, bus_req_o, stall_req_o, bus_err_o} !== {32'h0, 3'b001}) $display("FAIL tmo_done got %h want 1", {mem_rdata_o, bus_req_o, stall_req_o, bus_err_o}); else passed++;
        tick();
        stall_i = 0;
        @(negedge clk);
        checks++; if ({bus_req_o, bus_err_o} !== 2'b00) $display("FAIL tmo_err_pulse got %b want 00", {bus_req_o, bus_err_o}); else passed++;
        tick();
        quiet();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_done_stall();
        test_flush();
`ifdef DBUS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dmem_bus_if.md
# dmem_bus_if

Data-memory bus interface sitting directly downstream of the memory-access stage. It takes the stage's combinational memory request (address, write enable, byte select, write data, chip enable) and runs it as a registered request/acknowledge transaction on the external data bus. Wait states are absorbed by stalling the pipeline through the control unit. Read data returns to the memory-access stage, which does the lane extraction, on a word-aligned, big-endian-lane bus.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles to wait for `bus_ack_i` before abort. Only used with `DBUS_TIMEOUT_EN`. Range 1..255.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `mem_ce_i`  input  1  request valid from the memory-access stage.
- `mem_we_i`  input  1  1 = store, 0 = load.
- `mem_addr_i`  input  32  byte address.
- `mem_sel_i`  input  4  byte lanes; bit 3 = bits 31:24 = address offset 0.
- `mem_wdata_i`  input  32  store data, already lane-replicated.
- `stall_i`  input  1  pipeline held by another source; the MEM/WB register does not capture this cycle.
- `flush_i`  input  1  discard the instruction in the memory-access stage.
- `mem_rdata_o`  output  32  load data to the memory-access stage.
- `stall_req_o`  output  1  hold IF..MEM stages.
- `bus_req_o`  output  1  transaction request (registered).
- `bus_we_o`  output  1  write strobe (registered).
- `bus_addr_o`  output  32  `{mem_addr_i[31:2],2'b00}` (registered).
- `bus_sel_o`  output  4  byte enables (registered).
- `bus_wdata_o`  output  32  write data (registered).
- `bus_ack_i`  input  1  transaction complete; `bus_rdata_i` is valid in the same cycle.
- `bus_rdata_i`  input  32  read data.
- `bus_err_o`  output  1  one-cycle timeout indication (registered).

## Operation
- States:
  - IDLE: no transaction in flight.
  - BUSY: `bus_req_o` = 1, waiting for acknowledge.
  - DONE: result held for the memory-access stage.
  - DRAIN: flushed transaction still in flight on the bus.
- IDLE:
  - With `mem_ce_i` = 1 and `flush_i` = 0: latch `mem_we_i`, the aligned address, `mem_sel_i` and `mem_wdata_i` into the bus registers; set `bus_req_o`; go to BUSY.
  - With `flush_i` = 1: stay in IDLE.
- BUSY:
  - Bus outputs are held stable until acknowledge.
  - On `bus_ack_i` = 1: clear `bus_req_o`, capture `bus_rdata_i` (loads; stores capture 0) into the read buffer, go to DONE.
  - With `flush_i` = 1 and no ack: go to DRAIN.
  - With `flush_i` = 1 and ack in the same cycle: go to IDLE and discard the data.
- DONE: `mem_rdata_o` = read buffer.
  - `stall_i` = 0: go to IDLE (MEM/WB captures this cycle).
  - `stall_i` = 1: stay in DONE.
  - `flush_i` = 1: go to IDLE.
- DRAIN: keep `bus_req_o` until `bus_ack_i`, then go to IDLE. Data is never presented.
- `stall_req_o` (combinational) = `(IDLE & mem_ce_i & ~flush_i) | BUSY | DRAIN`. It is 0 in DONE.
- `mem_rdata_o` is 0 outside DONE.
- A store's side effect is committed once requested; a flush cannot cancel it.
- Reset (any state, including mid-transaction): state → IDLE; every output → 0. `stall_req_o` follows its equation, so it is 0 in IDLE unless `mem_ce_i` = 1 with `flush_i` = 0.

## Timing
- Zero-wait load, `mem_ce_i` rising in cycle 0:
  - Cycle 0: IDLE, stall.
  - Cycle 1: BUSY, ack arrives, stall.
  - Cycle 2: DONE, data valid, no stall; the pipeline advances at the end of cycle 2.
- With N wait states, DONE falls in cycle 2+N.
- Back-to-back memory instructions re-enter IDLE for one cycle between transactions; there is no bus pipelining.
- `bus_ack_i` is ignored outside BUSY and DRAIN.
- `bus_err_o` is high only in the first DONE cycle after a timeout.

## Configuration
- `DBUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY or DRAIN and increments each cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, clear `bus_req_o`.
  - From BUSY: go to DONE with read buffer = 0 and pulse `bus_err_o`.
  - From DRAIN: go to IDLE.
- Not defined: no counter; BUSY and DRAIN wait indefinitely; `bus_err_o` is tied to 0.

## Test plan
- Reset: drop `rst` low mid-BUSY with `bus_req_o` = 1 → next sample shows `bus_req_o` = 0, `mem_rdata_o` = 0 and state IDLE. After release with `mem_ce_i` = 0 → `stall_req_o` = 0.
- Load, 0 wait, `mem_addr_i` = 0x00000106, `bus_rdata_i` = 0x11223344:
  - `bus_addr_o` = 0x00000104.
  - `stall_req_o` = 1 for 2 cycles.
  - `mem_rdata_o` = 0x11223344 in cycle 2.
- Store, 3 wait states, `mem_sel_i` = 4'b0011, `mem_wdata_i` = 0xBEEFBEEF:
  - Bus outputs are stable for 4 cycles.
  - `bus_we_o` = 1.
  - `stall_req_o` = 1 for 5 cycles.
- DONE held by `stall_i` = 1 for 2 cycles → `mem_rdata_o` is held, no new `bus_req_o`, and the state returns to IDLE the cycle after `stall_i` falls.
- `flush_i` in BUSY without ack → DRAIN; `bus_req_o` held until ack; no DONE cycle; then IDLE.
- With `DBUS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, `bus_ack_i` tied 0 → `bus_req_o` drops after 4 BUSY cycles, then a DONE cycle with `mem_rdata_o` = 0 and `bus_err_o` = 1 for exactly 1 cycle.
